test_keep_ctrl: RTL and testbench
=================================

TEST_KEEP_CTRL -- requirements
Module: test_keep_ctrl

Interface
REQ-001 SHALL have parameter NUM_FAULTS, default 1031, meaning size of the fault list.
REQ-002 SHALL have parameter FI_W, default 11, meaning fault-index width.
REQ-003 SHALL have parameter VEC_W, default 33, meaning test-vector width.
REQ-004 SHALL have parameters DESIRED_COV (default 90, target coverage %), UT_LIMIT (default 20, max consecutive useless tests) and STEPS (default 20, coverage step %).
REQ-005 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: start in 1 begin session; vec_valid in 1; vec_ready out 1; vec_in in VEC_W candidate vector.
REQ-007 SHALL have ports: res_valid in 1 one fault result; res_idx in FI_W fault index; res_detect in 1 outputs differed; res_last in 1 final result of current vector.
REQ-008 SHALL have ports: keep_valid out 1; keep_ready in 1; keep_vec out VEC_W kept vector.
REQ-009 SHALL have ports: done out 1; coverage out 7 percent; kept_cnt out 16; total_cnt out 16.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT_VEC, COLLECT, DECIDE, MERGE, EMIT, DONE.
REQ-011 SHALL, in IDLE on start=1: clear both bitmaps and all counters, load exp=NUM_FAULTS/20 and cov_edg=STEPS, then go to WAIT_VEC.
REQ-012 SHALL assert vec_ready only in WAIT_VEC; on vec_valid&&vec_ready it SHALL latch vec_in, clear the CT bitmap and new_cnt, increment total_cnt and ut_cnt, and go to COLLECT.
REQ-013 SHALL, in COLLECT, for each res_valid beat with res_detect=1 and res_idx<NUM_FAULTS, set CT[res_idx]; new_cnt SHALL increment only if AT[res_idx]=0 and CT[res_idx] was 0 (duplicate beats counted once).
REQ-014 SHALL ignore res_idx>=NUM_FAULTS and SHALL ignore res_valid outside COLLECT.
REQ-015 SHALL, on a res_valid beat with res_last=1, process that beat and then go to DECIDE.
REQ-016 SHALL, in DECIDE (one cycle), update exp to exp/2 if new_cnt<exp, else to (new_cnt+exp)/2, using integer truncation.
REQ-017 SHALL keep the vector iff new_cnt>=updated exp and new_cnt>0; otherwise it SHALL go directly to the stop check.
REQ-018 SHALL, in MERGE (keep path, one cycle): OR CT into AT; add new_cnt to det_cnt; clear ut_cnt; increment kept_cnt; set coverage=(100*det_cnt)/NUM_FAULTS; if coverage>=cov_edg, add STEPS to cov_edg and halve exp; then go to EMIT.
REQ-019 SHALL, in EMIT, hold keep_valid=1 and keep_vec stable until keep_ready=1, then perform the stop check.
REQ-020 SHALL, at the stop check, go to DONE if coverage>=DESIRED_COV or ut_cnt>=UT_LIMIT, else go to WAIT_VEC.
REQ-021 SHALL hold done=1 in DONE until rst, with start ignored in DONE.
REQ-022 SHALL size exp, new_cnt and det_cnt at FI_W+1 bits, and SHALL make all arithmetic saturation-free for NUM_FAULTS<2^FI_W.

Reset
REQ-023 SHALL, on rst, immediately force state=IDLE, vec_ready=0, keep_valid=0, done=0, coverage=0, kept_cnt=0, total_cnt=0, keep_vec=0, and clear both bitmaps, including when rst occurs mid-COLLECT or mid-EMIT.

Structure
REQ-024 SHALL place the FSM state enum and the default constants (NUM_FAULTS, FI_W, VEC_W, DESIRED_COV, UT_LIMIT, STEPS) in shared package keep_ctrl_pkg.
REQ-025 SHALL contain one sub-module, fault_bitmap, holding the AT and CT bitmaps with set, test and merge ports.

Verification
REQ-026 SHALL verify the keep path: first vector with 60 distinct detects -> exp=55, kept, coverage=5, keep_vec equals the vector, kept_cnt=1.
REQ-027 SHALL verify the discard path: next vector with 10 new detects -> exp=27, no keep_valid, total_cnt=2, kept_cnt=1.
REQ-028 SHALL verify duplicates and range: res_idx 5 reported 3 times plus res_idx 2000 -> new_cnt=1.
REQ-029 SHALL verify the coverage step: det_cnt crossing 207 (20%) -> cov_edg=40 and exp halved in the same MERGE.
REQ-030 SHALL verify the stop on useless tests: 20 consecutive vectors with 0 detects -> done=1 after the 20th vector, with keep_ready held low during EMIT stalls.
REQ-031 SHALL verify reset mid-operation: rst asserted in COLLECT -> all outputs at reset values next cycle, and a new start restarts with exp=51.

Source files
------------

// File: rtl/keep_ctrl_pkg.sv
// Shared constants and FSM encoding for the test-vector keep controller.
// Default parameter values live here so the top and its bitmap agree.
package keep_ctrl_pkg;

    localparam int DEF_NUM_FAULTS  = 1031;
    localparam int DEF_FI_W        = 11;
    localparam int DEF_VEC_W       = 33;
    localparam int DEF_DESIRED_COV = 90;
    localparam int DEF_UT_LIMIT    = 20;
    localparam int DEF_STEPS       = 20;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_VEC = 3'd1,
        COLLECT  = 3'd2,
        DECIDE   = 3'd3,
        MERGE    = 3'd4,
        EMIT     = 3'd5,
        DONE     = 3'd6
    } keep_state_e;

endpackage

// File: rtl/fault_bitmap.sv
// Accumulated (AT) and current-test (CT) fault-detection bitmaps.
// Single index serves both the CT set and the AT/CT test lookups.
module fault_bitmap
    import keep_ctrl_pkg::*;
#(
    parameter int NUM_FAULTS = DEF_NUM_FAULTS,
    parameter int FI_W       = DEF_FI_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clearAll,
    input  logic            clearCt,
    input  logic            setEn,
    input  logic [FI_W-1:0] idx,
    input  logic            mergeEn,
    output logic            atBit,
    output logic            ctBit
);

    logic [NUM_FAULTS-1:0] atMap_r;
    logic [NUM_FAULTS-1:0] ctMap_r;

    assign atBit = atMap_r[idx];
    assign ctBit = ctMap_r[idx];

    // Accumulated detections: cleared per session, grows by merging CT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            atMap_r <= '0;
        end else if (clearAll) begin
            atMap_r <= '0;
        end else if (mergeEn) begin
            atMap_r <= atMap_r | ctMap_r;
        end
    end

    // Detections of the vector under evaluation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctMap_r <= '0;
        end else if (clearAll || clearCt) begin
            ctMap_r <= '0;
        end else if (setEn) begin
            ctMap_r[idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/test_keep_ctrl.sv
// Decides which candidate test vectors are worth keeping, based on how many
// previously-undetected faults each one detects versus an adaptive threshold.
module test_keep_ctrl
    import keep_ctrl_pkg::*;
#(
    parameter int NUM_FAULTS  = DEF_NUM_FAULTS,
    parameter int FI_W        = DEF_FI_W,
    parameter int VEC_W       = DEF_VEC_W,
    parameter int DESIRED_COV = DEF_DESIRED_COV,
    parameter int UT_LIMIT    = DEF_UT_LIMIT,
    parameter int STEPS       = DEF_STEPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [VEC_W-1:0] vec_in,
    input  logic             res_valid,
    input  logic [FI_W-1:0]  res_idx,
    input  logic             res_detect,
    input  logic             res_last,
    output logic             keep_valid,
    input  logic             keep_ready,
    output logic [VEC_W-1:0] keep_vec,
    output logic             done,
    output logic [6:0]       coverage,
    output logic [15:0]      kept_cnt,
    output logic [15:0]      total_cnt
);

    localparam int             CW        = FI_W + 1;
    localparam logic [CW-1:0]  EXP_INIT  = CW'(NUM_FAULTS / 20);
    localparam logic [FI_W:0]  NF_W      = (FI_W + 1)'(NUM_FAULTS);
    localparam logic [6:0]     DES_COV_W = 7'(DESIRED_COV);
    localparam logic [7:0]     STEPS_W   = 8'(STEPS);
    localparam logic [15:0]    UT_LIM_W  = 16'(UT_LIMIT);

    keep_state_e   state_r;
    keep_state_e   stateNext_s;
    logic [CW-1:0] expVal_r;
    logic [CW-1:0] newCnt_r;
    logic [CW-1:0] detCnt_r;
    logic [7:0]    covEdg_r;
    logic [15:0]   utCnt_r;
    logic [CW-1:0] expNext_s;
    logic [CW-1:0] detSum_s;
    logic [6:0]    covNext_s;
    logic          keepIt_s;
    logic          stopNow_s;
    logic          resHit_s;
    logic          clearAll_s;
    logic          clearCt_s;
    logic          merge_s;
    logic          atBit_s;
    logic          ctBit_s;

    fault_bitmap #(
        .NUM_FAULTS (NUM_FAULTS),
        .FI_W       (FI_W)
    ) u_bitmap (
        .clk      (clk),
        .rst      (rst),
        .clearAll (clearAll_s),
        .clearCt  (clearCt_s),
        .setEn    (resHit_s),
        .idx      (res_idx),
        .mergeEn  (merge_s),
        .atBit    (atBit_s),
        .ctBit    (ctBit_s)
    );

    // Threshold update, keep decision, coverage and bitmap controls.
    always_comb begin
        if (newCnt_r < expVal_r) begin
            expNext_s = expVal_r >> 1;
        end else begin
            expNext_s = CW'(({1'b0, newCnt_r} + {1'b0, expVal_r}) >> 1);
        end
        keepIt_s   = (newCnt_r >= expNext_s) && (newCnt_r != '0);
        detSum_s   = detCnt_r + newCnt_r;
        covNext_s  = 7'((32'(detSum_s) * 32'd100) / 32'(NUM_FAULTS));
        stopNow_s  = (coverage >= DES_COV_W) || (utCnt_r >= UT_LIM_W);
        resHit_s   = (state_r == COLLECT) && res_valid && res_detect &&
                     ({1'b0, res_idx} < NF_W);
        clearAll_s = (state_r == IDLE) && start;
        clearCt_s  = (state_r == WAIT_VEC) && vec_valid;
        merge_s    = (state_r == MERGE);
    end

    // Next-state logic; the stop check is shared by DECIDE and EMIT.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE:     stateNext_s = start ? WAIT_VEC : IDLE;
            WAIT_VEC: stateNext_s = vec_valid ? COLLECT : WAIT_VEC;
            COLLECT:  stateNext_s = (res_valid && res_last) ? DECIDE : COLLECT;
            DECIDE: begin
                if (keepIt_s) begin
                    stateNext_s = MERGE;
                end else if (stopNow_s) begin
                    stateNext_s = DONE;
                end else begin
                    stateNext_s = WAIT_VEC;
                end
            end
            MERGE:    stateNext_s = EMIT;
            EMIT: begin
                if (!keep_ready) begin
                    stateNext_s = EMIT;
                end else if (stopNow_s) begin
                    stateNext_s = DONE;
                end else begin
                    stateNext_s = WAIT_VEC;
                end
            end
            DONE:     stateNext_s = DONE;
            default:  stateNext_s = IDLE;
        endcase
    end

    // State register with handshake/status flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            vec_ready  <= 1'b0;
            keep_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_r    <= stateNext_s;
            vec_ready  <= (stateNext_s == WAIT_VEC);
            keep_valid <= (stateNext_s == EMIT);
            done       <= (stateNext_s == DONE);
        end
    end

    // Session counters, thresholds and the latched candidate vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expVal_r  <= '0;
            newCnt_r  <= '0;
            detCnt_r  <= '0;
            covEdg_r  <= 8'd0;
            utCnt_r   <= 16'd0;
            coverage  <= 7'd0;
            kept_cnt  <= 16'd0;
            total_cnt <= 16'd0;
            keep_vec  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        expVal_r  <= EXP_INIT;
                        newCnt_r  <= '0;
                        detCnt_r  <= '0;
                        covEdg_r  <= STEPS_W;
                        utCnt_r   <= 16'd0;
                        coverage  <= 7'd0;
                        kept_cnt  <= 16'd0;
                        total_cnt <= 16'd0;
                    end
                end
                WAIT_VEC: begin
                    if (vec_valid) begin
                        keep_vec  <= vec_in;
                        newCnt_r  <= '0;
                        total_cnt <= total_cnt + 16'd1;
                        utCnt_r   <= utCnt_r + 16'd1;
                    end
                end
                COLLECT: begin
                    // A fault counts once: not already accumulated, not seen this vector.
                    if (resHit_s && !atBit_s && !ctBit_s) begin
                        newCnt_r <= newCnt_r + CW'(1);
                    end
                end
                DECIDE: expVal_r <= expNext_s;
                MERGE: begin
                    detCnt_r <= detSum_s;
                    utCnt_r  <= 16'd0;
                    kept_cnt <= kept_cnt + 16'd1;
                    coverage <= covNext_s;
                    if ({1'b0, covNext_s} >= covEdg_r) begin
                        covEdg_r <= covEdg_r + STEPS_W;
                        expVal_r <= expVal_r >> 1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_test_keep_ctrl.sv
// Self-checking bench for test_keep_ctrl: directed table, corner sequences,
// and randomized vectors against a set-based reference model.
module tb_test_keep_ctrl;
    import keep_ctrl_pkg::*;

    localparam int NF = DEF_NUM_FAULTS;
    localparam int FW = DEF_FI_W;
    localparam int VW = DEF_VEC_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          vec_valid;
    logic          vec_ready;
    logic [VW-1:0] vec_in;
    logic          res_valid;
    logic [FW-1:0] res_idx;
    logic          res_detect;
    logic          res_last;
    logic          keep_valid;
    logic          keep_ready;
    logic [VW-1:0] keep_vec;
    logic          done;
    logic [6:0]    coverage;
    logic [15:0]   kept_cnt;
    logic [15:0]   total_cnt;

    always #5 clk = ~clk;

    test_keep_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .vec_in     (vec_in),
        .res_valid  (res_valid),
        .res_idx    (res_idx),
        .res_detect (res_detect),
        .res_last   (res_last),
        .keep_valid (keep_valid),
        .keep_ready (keep_ready),
        .keep_vec   (keep_vec),
        .done       (done),
        .coverage   (coverage),
        .kept_cnt   (kept_cnt),
        .total_cnt  (total_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: the set of faults detected so far plus scalars.
    bit mAt [NF];
    int mExp, mEdg, mDet, mKept, mTotal, mUt, mCov;
    bit mDone;

    int beatIdx[$];
    bit beatDet[$];

    typedef struct {
        int first;
        int count;
        bit keep;
        int expv;
        int cov;
        int kept;
        int edg;
    } vec_rec_t;

    vec_rec_t tbl [4];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, req);
        end
    endtask

    task automatic modelStart;
        foreach (mAt[i]) mAt[i] = 1'b0;
        mExp = NF / 20;
        mEdg = DEF_STEPS;
        mDet = 0; mKept = 0; mTotal = 0; mUt = 0; mCov = 0; mDone = 1'b0;
    endtask

    function automatic int modelVector(output bit keep);
        bit seen [NF];
        int n = 0;
        mTotal++;
        mUt++;
        foreach (beatIdx[i]) begin
            if (beatDet[i] && beatIdx[i] < NF && !mAt[beatIdx[i]] && !seen[beatIdx[i]]) begin
                seen[beatIdx[i]] = 1'b1;
                n++;
            end
        end
        mExp = (n < mExp) ? mExp / 2 : (n + mExp) / 2;
        keep = (n >= mExp) && (n > 0);
        if (keep) begin
            foreach (seen[i]) if (seen[i]) mAt[i] = 1'b1;
            mDet += n;
            mUt = 0;
            mKept++;
            mCov = (100 * mDet) / NF;
            if (mCov >= mEdg) begin
                mEdg += DEF_STEPS;
                mExp = mExp / 2;
            end
        end
        mDone = (mCov >= DEF_DESIRED_COV) || (mUt >= DEF_UT_LIMIT);
        return n;
    endfunction

    task automatic doReset;
        rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_in = '0;
        res_valid = 1'b0; res_idx = '0; res_detect = 1'b0; res_last = 1'b0;
        keep_ready = 1'b0;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic startSession;
        start = 1'b1;
        tick;
        start = 1'b0;
        modelStart;
        check("start_exp", dut.expVal_r, 51);
        check("start_ready", vec_ready, 1);
    endtask

    task automatic runVector(input logic [VW-1:0] v, input int stall, input bit gaps, output bit keptOut);
        int  n;
        int  cyc;
        bit  mk;
        cyc = 0;
        while (!vec_ready && cyc < 50) begin tick; cyc++; end
        check("vec_ready_wait", vec_ready, 1);
        if (gaps) begin
            // Results outside COLLECT must be ignored.
            res_valid = 1'b1; res_detect = 1'b1; res_last = 1'b1;
            res_idx = FW'($urandom_range(0, NF - 1));
            tick;
            res_valid = 1'b0; res_detect = 1'b0; res_last = 1'b0;
        end
        vec_valid = 1'b1; vec_in = v;
        tick;
        vec_valid = 1'b0; vec_in = '0;
        check("vec_ready_collect", vec_ready, 0);
        if (beatIdx.size() == 0) begin
            beatIdx.push_back(0);
            beatDet.push_back(1'b0);
        end
        foreach (beatIdx[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) tick;
            res_valid = 1'b1; res_idx = FW'(beatIdx[i]); res_detect = beatDet[i];
            res_last = (i == beatIdx.size() - 1);
            tick;
            res_valid = 1'b0; res_detect = 1'b0; res_last = 1'b0;
        end
        n = modelVector(mk);
        check("new_cnt", dut.newCnt_r, n);
        cyc = 0;
        while (!keep_valid && !vec_ready && !done && cyc < 10) begin tick; cyc++; end
        check("keep_decision", keep_valid, mk);
        keptOut = keep_valid;
        if (keep_valid) begin
            check("keep_vec", keep_vec, v);
            check("kept_cnt_emit", kept_cnt, mKept);
            check("coverage_emit", coverage, mCov);
            for (int s = 0; s < stall; s++) begin
                tick;
                check("keep_valid_hold", keep_valid, 1);
                check("keep_vec_hold", keep_vec, v);
            end
            keep_ready = 1'b1;
            tick;
            keep_ready = 1'b0;
            check("keep_valid_drop", keep_valid, 0);
        end
        check("done", done, mDone);
        check("vec_ready_after", vec_ready, !mDone);
        check("total_cnt", total_cnt, mTotal);
        check("kept_cnt", kept_cnt, mKept);
        check("coverage", coverage, mCov);
        check("exp", dut.expVal_r, mExp);
        check("cov_edg", dut.covEdg_r, mEdg);
    endtask

    initial begin
        bit kk;
        tbl[0] = '{first: 0,  count: 60,  keep: 1'b1, expv: 55, cov: 5,  kept: 1, edg: 20};
        tbl[1] = '{first: 60, count: 10,  keep: 1'b0, expv: 27, cov: 5,  kept: 1, edg: 20};
        tbl[2] = '{first: 70, count: 150, keep: 1'b1, expv: 44, cov: 20, kept: 2, edg: 40};
        tbl[3] = '{first: 0,  count: 0,   keep: 1'b0, expv: 22, cov: 20, kept: 2, edg: 40};

        rst = 1'b1;
        doReset;
        check("rst_vec_ready", vec_ready, 0);
        check("rst_done", done, 0);
        check("rst_kept", kept_cnt, 0);
        startSession;

        // Keep, discard, coverage step, empty vector.
        for (int r = 0; r < 4; r++) begin
            beatIdx.delete(); beatDet.delete();
            for (int k = 0; k < tbl[r].count; k++) begin
                beatIdx.push_back(tbl[r].first + k);
                beatDet.push_back(1'b1);
            end
            runVector(VW'(64'h1_2345_6700 + 64'(r)), 3, 1'b0, kk);
            check("tbl_keep", kk, tbl[r].keep);
            check("tbl_exp", dut.expVal_r, tbl[r].expv);
            check("tbl_cov", coverage, tbl[r].cov);
            check("tbl_kept", kept_cnt, tbl[r].kept);
            check("tbl_edg", dut.covEdg_r, tbl[r].edg);
        end
        check("tbl_total", total_cnt, 4);

        // Reset asserted while collecting results.
        vec_valid = 1'b1; vec_in = VW'(64'h0_DEAD_BEEF);
        tick;
        vec_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            res_valid = 1'b1; res_detect = 1'b1; res_idx = FW'(300 + k);
            tick;
        end
        res_valid = 1'b0; res_detect = 1'b0;
        rst = 1'b1;
        tick;
        check("mid_rst_vec_ready", vec_ready, 0);
        check("mid_rst_keep_valid", keep_valid, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_cov", coverage, 0);
        check("mid_rst_kept", kept_cnt, 0);
        check("mid_rst_total", total_cnt, 0);
        check("mid_rst_keep_vec", keep_vec, 0);
        check("mid_rst_at", |dut.u_bitmap.atMap_r, 0);
        check("mid_rst_ct", |dut.u_bitmap.ctMap_r, 0);
        rst = 1'b0;
        tick;
        startSession;

        // Duplicate reports and an out-of-range index count once / not at all.
        beatIdx = '{5, 5, 5, 2000};
        beatDet = '{1'b1, 1'b1, 1'b1, 1'b1};
        runVector(VW'(64'h0_0000_0005), 0, 1'b0, kk);
        check("dup_range_newcnt", dut.newCnt_r, 1);
        check("dup_range_exp", dut.expVal_r, 25);

        // Twenty useless vectors end the session; keep_ready stays low.
        doReset;
        startSession;
        for (int u = 0; u < 20; u++) begin
            beatIdx.delete(); beatDet.delete();
            runVector(VW'(u), 0, 1'b0, kk);
            if (u == 18) check("useless_19_not_done", done, 0);
        end
        check("useless_20_done", done, 1);
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        check("done_ignores_start", done, 1);
        check("done_no_ready", vec_ready, 0);

        // Randomized vectors against the reference model.
        doReset;
        startSession;
        for (int t = 0; t < 60; t++) begin
            int nb;
            if (done) begin
                doReset;
                startSession;
            end
            beatIdx.delete(); beatDet.delete();
            nb = $urandom_range(1, 40);
            for (int k = 0; k < nb; k++) begin
                if (k > 0 && $urandom_range(0, 4) == 0) beatIdx.push_back(beatIdx[k - 1]);
                else beatIdx.push_back(int'($urandom_range(0, 1100)));
                beatDet.push_back($urandom_range(0, 3) != 0);
            end
            runVector(VW'({$urandom, $urandom}), int'($urandom_range(0, 3)), 1'b1, kk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
